xrisc_mmio_uart_tx: RTL

- Memory-mapped transmit peripheral on the XRISC single-cycle core's data-memory write bus; consumes the core's MemWrite/DataAdr/WriteData outputs in parallel with data memory.
- Writes to its TXDATA address push a byte into a small FIFO; an FSM serializes bytes as 8N1 frames on `tx`.
- A STATUS word is returned combinationally for the core's load path.

---
 rtl/xrisc_mmio_uart_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/xrisc_mmio_uart_tx.sv
// xrisc_mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting on the XRISC core's data-memory
//   write bus. Stores to BASE_ADDR push a byte into a DEPTH-entry FIFO. An FSM
//   drains the FIFO and serializes frames on tx. BASE_ADDR+4 reads back STATUS.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   MemWrite     : core store strobe
//   DataAdr      : core data address
//   WriteData    : core store data (bits [7:0] used)
//   ReadData     : STATUS when DataAdr==BASE_ADDR+4, else 0 (combinational)
//                  {16'b0, drop_cnt, 5'b0, tx_busy, empty, full}
//   tx           : registered serial output, idles high
//   tx_busy      : FSM not in IDLE
//   irq_empty    : FIFO empty and FSM in IDLE
module xrisc_mmio_uart_tx #(
  parameter int          DEPTH        = 4,
  parameter int          CLKS_PER_BIT = 4,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        tx_busy,
  output logic        irq_empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CTR_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CNTW-1:0] r_count;
  logic [7:0]      r_drop_cnt;
  logic [CW-1:0]   r_bit_ctr, w_bit_ctr_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [7:0]      r_shreg, w_shreg_nxt;
  logic            r_tx, w_tx_nxt;
  logic            w_pop, w_push_req, w_push;
  logic            w_full, w_empty, w_ctr_done;
  logic            w_unused;

  assign w_unused   = ^WriteData[31:8];
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_ctr_done = (r_bit_ctr == CTR_LAST);
  assign w_push_req = MemWrite && (DataAdr == BASE_ADDR);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Next-state / datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_ctr_nxt = r_bit_ctr + CW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bit_ctr_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rptr];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_ctr_done) begin
          w_bit_ctr_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_ctr_done) begin
          w_bit_ctr_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_shreg_nxt   = {1'b0, r_shreg[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_ctr_done) begin
          w_bit_ctr_nxt = '0;
          // Chain straight into the next frame when more data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shreg_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // tx is registered from the next state so it changes exactly on the edge.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_ctr <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_ctr <= w_bit_ctr_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // FIFO storage: contents need no reset, only the pointers/count do.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign tx        = r_tx;
  assign tx_busy   = (r_state != S_IDLE);
  assign irq_empty = w_empty && (r_state == S_IDLE);
  assign ReadData  = (DataAdr == BASE_ADDR + 32'd4) ?
                     {16'h0, r_drop_cnt, 5'b0, tx_busy, w_empty, w_full} : 32'h0;

endmodule
